crc_frame_checker: RTL and testbench
====================================

# crc_frame_checker

Receive-side counterpart of the CRC generator: consumes a fixed-length frame of `p_width`-bit payload words followed by one CRC word. It recomputes the CRC over the payload, compares it with the received CRC and reports pass/fail once per frame. It also keeps running frame and error counters. It sits at the sink end of the hash/CRC pipeline, in front of any consumer that must reject corrupted frames.

## Interface
- `p_width`, 8, payload word width; also the CRC width.
- `p_polynom`, 8'h31, generator polynomial; implicit x^p_width term omitted.
- `p_init`, 8'h00, CRC register value at the start of every frame.
- `p_len`, 128, payload bits per frame; must be a multiple of `p_width`; `p_len/p_width` must be at least 1.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of the partial frame.
- `in_data`  in  `p_width`  payload or CRC word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `chk_valid`  out  1  one-cycle pulse; result fields are valid.
- `chk_ok`  out  1  computed CRC equals received CRC.
- `chk_crc`  out  `p_width`  CRC computed over the payload.
- `chk_rx_crc`  out  `p_width`  CRC word received.
- `frame_cnt`  out  16  frames checked; saturating.
- `err_cnt`  out  16  frames with mismatch; saturating.

## Operation
- Handshake: a word transfers when `in_valid && in_ready`. No transfer means no state change.
- CRC is computed MSB-first, non-reflected, with no final XOR.
- Per bit `d` (MSB first): `fb = crc[p_width-1] ^ d`, then `crc = (crc << 1) ^ (fb ? p_polynom : 0)`.
- One full word (`p_width` bit steps) is processed per accepted transfer.
- FSM states:
  - S_DATA: `in_ready=1`. Each transfer updates the CRC register and increments the word counter. On the transfer of word `p_len/p_width - 1`, go to S_CRC.
  - S_CRC: `in_ready=1`. On a transfer, latch `in_data` into `chk_rx_crc` and latch the CRC register into `chk_crc`, then go to S_REPORT.
  - S_REPORT: `in_ready=0`. `chk_valid=1` and `chk_ok=(chk_crc==chk_rx_crc)`. `frame_cnt` is incremented; `err_cnt` is incremented if `!chk_ok`. The CRC register reloads `p_init` and the word counter clears. Next state is S_DATA.
- `flush` in S_DATA or S_CRC: go to S_DATA, reload `p_init`, clear the word counter. Any word transferred in the same cycle is dropped. Counters and the last result fields are unchanged.
- `flush` in S_REPORT is ignored; the report completes.
- Counters saturate at 16'hFFFF; no wrap.

## Timing
- Reset values:
  - state S_DATA, word counter 0, CRC register `p_init`.
  - `in_ready=1`, `chk_valid=0`, `chk_ok=0`, `chk_crc=0`, `chk_rx_crc=0`, `frame_cnt=0`, `err_cnt=0`.
- `rst` has priority over `flush` and over any transfer. Reset mid-frame discards the partial frame and produces no `chk_valid`.
- `chk_valid` rises exactly 1 cycle after the CRC-word transfer and lasts 1 cycle.
- The counters show their updated values the cycle after `chk_valid`.
- `chk_crc`, `chk_rx_crc` and `chk_ok` hold until the next report.
- Throughput is one frame per `p_len/p_width + 2` cycles at full `in_valid`: the S_REPORT cycle is the only bubble.
- `in_ready` is a registered-state decode; there is no combinational path from `in_valid`.
- The CRC register update is a single-cycle combinational unroll of `p_width` bit steps feeding a register.

## Structure
- Package `crc_pkg`:
  - state enum `crc_chk_state_t` (S_DATA, S_CRC, S_REPORT).
  - function `crc_word_step(crc, data, poly)`, shared with the generator so both ends use an identical polynomial implementation.
  - counter width constant `CRC_CNT_W=16`.
- Sub-module `crc_word_update`: combinational next-CRC from (crc, word) using `crc_word_step`. It is instanced once here and reusable by the generator.
- Top level holds the FSM, word counter, result registers and saturating counters.

## Test plan
- Frame of 16×8'h00 plus CRC 8'h00 -> `chk_valid` pulse, `chk_ok=1`, `chk_crc=8'h00`, `frame_cnt=1`, `err_cnt=0`.
- 15×8'h00, 8'h01, then CRC 8'h31 -> `chk_ok=1`, `chk_crc=8'h31`. The same payload with last byte 8'h02 and CRC 8'h62 -> `chk_ok=1`.
- 15×8'h00, 8'h01, then CRC 8'h30 -> `chk_ok=0`, `chk_crc=8'h31`, `chk_rx_crc=8'h30`, `err_cnt=1`.
- `in_valid` toggled randomly across a 16×8'h00 + 8'h00 frame -> result identical to the back-to-back case. Also check `in_ready=0` only in the report cycle and a back-to-back frame count of 18 cycles per frame.
- `flush` after word 7, then a full good frame -> exactly one `chk_valid`, `chk_ok=1`. Separately, `rst` after word 10 -> no `chk_valid`, counters 0, `in_ready=1`.
- Force `err_cnt` to 16'hFFFE via 2 bad frames after a preload (or long run) -> `err_cnt` reaches 16'hFFFF and stays there on further bad frames.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC types, constants and the word-wide polynomial step
package crc_pkg;
    localparam int CRC_CNT_W = 16;
    localparam int CRC_MAX_W = 32;

    typedef enum logic [1:0] {S_DATA, S_CRC, S_REPORT} crc_chk_state_t;

    // Operands arrive left-justified in CRC_MAX_W bits so one loop serves every
    // width up to CRC_MAX_W; only the top `width` data bits are consumed.
    function automatic logic [CRC_MAX_W-1:0] crc_word_step(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [CRC_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   width
    );
        logic [CRC_MAX_W-1:0] c;
        c = crc;
        for (int i = CRC_MAX_W - 1; i >= 0; i--)
            if (i >= CRC_MAX_W - width)
                c = (c << 1) ^ ((c[CRC_MAX_W-1] ^ data[i]) ? poly : '0);
        return c;
    endfunction
endpackage

// File: rtl/crc_word_update.sv
// crc_word_update: combinational next-CRC over one p_width-bit word, MSB first
module crc_word_update
    import crc_pkg::*;
#(
    parameter int                 p_width   = 8,
    parameter logic [p_width-1:0] p_polynom = 8'h31
) (
    input  logic [p_width-1:0] crc,
    input  logic [p_width-1:0] data,
    output logic [p_width-1:0] crc_next
);
    localparam int SH = CRC_MAX_W - p_width;

    assign crc_next = p_width'(crc_word_step(CRC_MAX_W'(crc) << SH,
                                             CRC_MAX_W'(data) << SH,
                                             CRC_MAX_W'(p_polynom) << SH,
                                             p_width) >> SH);
endmodule

// File: rtl/crc_frame_checker.sv
// crc_frame_checker: recomputes a frame CRC, compares it with the received word and counts results
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter int                 p_width   = 8,
    parameter logic [p_width-1:0] p_polynom = 8'h31,
    parameter logic [p_width-1:0] p_init    = 8'h00,
    parameter int                 p_len     = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [p_width-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 chk_valid,
    output logic                 chk_ok,
    output logic [p_width-1:0]   chk_crc,
    output logic [p_width-1:0]   chk_rx_crc,
    output logic [CRC_CNT_W-1:0] frame_cnt,
    output logic [CRC_CNT_W-1:0] err_cnt
);
    localparam int WORDS = p_len / p_width;
    localparam int CW    = WORDS > 1 ? $clog2(WORDS) : 1;

    crc_chk_state_t     state, state_nxt;
    logic [CW-1:0]      wcnt;
    logic [p_width-1:0] crc, crc_nxt;
    logic               xfer, last;

    assign in_ready  = state != S_REPORT;
    assign chk_valid = state == S_REPORT;
    assign xfer      = in_valid && in_ready;
    assign last      = wcnt == CW'(WORDS - 1);

    crc_word_update #(.p_width(p_width), .p_polynom(p_polynom)) u_upd (
        .crc      (crc),
        .data     (in_data),
        .crc_next (crc_nxt)
    );

    // state register
    always_ff @(posedge clk)
        state <= rst ? S_DATA : state_nxt;

    // next state: flush aborts the frame except while reporting
    always_comb begin
        state_nxt = state;
        case (state)
            S_DATA:   state_nxt = flush ? S_DATA : (xfer && last) ? S_CRC : S_DATA;
            S_CRC:    state_nxt = flush ? S_DATA : xfer ? S_REPORT : S_CRC;
            default:  state_nxt = S_DATA;
        endcase
    end

    // CRC accumulation, result capture and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt       <= '0;
            crc        <= p_init;
            chk_ok     <= 1'b0;
            chk_crc    <= '0;
            chk_rx_crc <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else if (state == S_REPORT) begin
            wcnt      <= '0;
            crc       <= p_init;
            frame_cnt <= frame_cnt + CRC_CNT_W'(frame_cnt != '1);
            err_cnt   <= err_cnt + CRC_CNT_W'(!chk_ok && err_cnt != '1);
        end else if (flush) begin
            wcnt <= '0;
            crc  <= p_init;
        end else if (xfer && state == S_DATA) begin
            wcnt <= wcnt + 1'b1;
            crc  <= crc_nxt;
        end else if (xfer) begin
            chk_rx_crc <= in_data;
            chk_crc    <= crc;
            chk_ok     <= crc == in_data;
        end
    end
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: scoreboard bench with directed, hand-computed CRC vectors
module tb_crc_frame_checker;
    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic [7:0]  in_data = 0;
    logic        in_valid = 0;
    logic        in_ready, chk_valid, chk_ok;
    logic [7:0]  chk_crc, chk_rx_crc;
    logic [15:0] frame_cnt, err_cnt;

    typedef struct {
        logic        ok;
        logic [7:0]  crc;
        logic [7:0]  rx;
        logic [15:0] frames;
        logic [15:0] errs;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    bit          cnt_chk = 0;
    int          compared = 0, mismatched = 0;
    int          cyc = 0, v_last = 0, v_prev = 0;
    logic [15:0] m_frames = 0, m_errs = 0;

    crc_frame_checker dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_crc(chk_crc),
        .chk_rx_crc(chk_rx_crc), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every report, checks counters one cycle later
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_vs_report", in_ready, !chk_valid);
            if (cnt_chk) begin
                check("frame_cnt", frame_cnt, cur.frames);
                check("err_cnt", err_cnt, cur.errs);
                cnt_chk = 0;
            end
            if (chk_valid) begin
                v_prev = v_last;
                v_last = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_chk_valid", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check("chk_ok", chk_ok, cur.ok);
                    check("chk_crc", chk_crc, cur.crc);
                    check("chk_rx_crc", chk_rx_crc, cur.rx);
                    cnt_chk = 1;
                end
            end
        end
    end

    task automatic put(input logic [7:0] d);
        bit acc = 0;
        in_data  = d;
        in_valid = 1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("transfer_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] last, input logic [7:0] rx,
                         input logic [7:0] crc, input bit gaps);
        exp_t e;
        e.ok  = crc == rx;
        e.crc = crc;
        e.rx  = rx;
        if (m_frames != 16'hFFFF) m_frames++;
        if (!e.ok && m_errs != 16'hFFFF) m_errs++;
        e.frames = m_frames;
        e.errs   = m_errs;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            put(i == 15 ? last : 8'h00);
        end
        if (gaps) idle($urandom_range(0, 2));
        put(rx);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_chk_ok", chk_ok, 0);
        check("rst_chk_crc", chk_crc, 0);
        check("rst_chk_rx_crc", chk_rx_crc, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);

        frame(8'h00, 8'h00, 8'h00, 0);
        frame(8'h01, 8'h31, 8'h31, 0);
        frame(8'h02, 8'h62, 8'h62, 0);
        frame(8'h80, 8'h7A, 8'h7A, 0);
        frame(8'h03, 8'h53, 8'h53, 0);
        frame(8'h01, 8'h30, 8'h31, 0);
        idle(3);
        frame(8'h00, 8'h00, 8'h00, 1);
        idle(3);

        frame(8'h01, 8'h31, 8'h31, 0);
        frame(8'h02, 8'h62, 8'h62, 0);
        idle(3);
        check("frame_period", v_last - v_prev, 18);

        for (int i = 0; i < 8; i++) put(8'h5A);
        in_data  = 8'hAA;
        in_valid = 1;
        flush    = 1;
        @(posedge clk);
        #1;
        flush    = 0;
        in_valid = 0;
        frame(8'h01, 8'h31, 8'h31, 0);
        idle(3);

        for (int i = 0; i < 10; i++) put(8'h11);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        m_frames = 0;
        m_errs   = 0;
        idle(20);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_chk_crc", chk_crc, 0);
        frame(8'h02, 8'h62, 8'h62, 0);
        idle(3);

        force dut.err_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.err_cnt;
        m_errs = 16'hFFFE;
        idle(1);
        frame(8'h80, 8'h00, 8'h7A, 0);
        frame(8'h00, 8'h01, 8'h00, 0);
        frame(8'h01, 8'h62, 8'h31, 0);
        idle(4);
        check("err_cnt_saturated", err_cnt, 16'hFFFF);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
